// File: rtl/mcd_pkg.sv
// mcd_pkg: shared defaults and helpers for the multi-channel clock divider
package mcd_pkg;
  localparam int CNT_W_DEF = 32;
  localparam int DEF_DIV_DEF = 100;
  localparam int DEF_HIGH_DEF = DEF_DIV_DEF / 2;
  localparam int MIN_DIV = 2;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mcd_if.sv
// mcd_if: configuration request bus for the multi-channel clock divider
interface mcd_if import mcd_pkg::*; #(
  parameter int CH_W = 1,
  parameter int CNT_W = CNT_W_DEF
);
  logic cfg_valid;
  logic cfg_ready;
  logic cfg_err;
  logic [CH_W-1:0] cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_high, input cfg_ready, cfg_err);
  modport slave (input cfg_valid, cfg_ch, cfg_div, cfg_high, output cfg_ready, cfg_err);
endinterface

// File: rtl/mcd_channel.sv
// mcd_channel: one divider channel whose new settings land only on a period boundary
module mcd_channel import mcd_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF,
  parameter int DEF_HIGH = DEF_HIGH_DEF
) (
  input  logic I_CLK,
  input  logic rst,
  input  logic en,
  input  logic acc,
  input  logic [CNT_W-1:0] div_in,
  input  logic [CNT_W-1:0] high_in,
  output logic pend,
  output logic dclk,
  output logic tick
);
  logic [CNT_W-1:0] count, div_act, high_act, div_pend, high_pend;
  logic wrap, apply;
  // last cycle of a period; pending settings land there, or at once while disabled
  always_comb begin
    wrap = count == div_act - 1'b1;
    apply = pend && (wrap || !en);
  end
  // period counter, active/pending settings and registered outputs
  always_ff @(posedge I_CLK or posedge rst)
    if (rst) begin
      count <= '0;
      div_act <= CNT_W'(DEF_DIV);
      high_act <= CNT_W'(DEF_HIGH);
      div_pend <= CNT_W'(DEF_DIV);
      high_pend <= CNT_W'(DEF_HIGH);
      pend <= 1'b0;
      dclk <= 1'b0;
      tick <= 1'b0;
    end else begin
      dclk <= en && count < high_act;
      tick <= en && count == '0;
      count <= (wrap || !en) ? '0 : count + 1'b1;
      if (apply) begin
        div_act <= div_pend;
        high_act <= high_pend;
        pend <= 1'b0;
      end else if (acc) begin
        div_pend <= div_in < CNT_W'(MIN_DIV) ? CNT_W'(MIN_DIV) : div_in;
        high_pend <= high_in;
        pend <= 1'b1;
      end
    end
endmodule

// File: rtl/multi_clk_divider.sv
// multi_clk_divider: bank of independently programmable clock dividers behind one config port
module multi_clk_divider import mcd_pkg::*; #(
  parameter int CHANNELS = 2,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEF_DIV = DEF_DIV_DEF,
  parameter int DEF_HIGH = DEF_DIV / 2
) (
  input  logic I_CLK,
  input  logic rst,
  input  logic [CHANNELS-1:0] en,
  mcd_if.slave cfg,
  output logic [CHANNELS-1:0] O_CLK,
  output logic [CHANNELS-1:0] O_TICK
);
  localparam int CH_W = ch_w(CHANNELS);
  localparam int PW = 2 ** CH_W;
  logic [CHANNELS-1:0] pend;
  logic [PW-1:0] pend_x;
  logic bad;
  // ready mux; unused channel codes read as never-pending so they are always accepted
  always_comb begin
    pend_x = PW'(pend);
    bad = 32'(cfg.cfg_ch) >= CHANNELS;
    cfg.cfg_ready = !pend_x[cfg.cfg_ch];
  end
  // flag requests addressed to a channel that does not exist
  always_ff @(posedge I_CLK or posedge rst)
    if (rst) cfg.cfg_err <= 1'b0;
    else cfg.cfg_err <= cfg.cfg_valid && bad;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    mcd_channel #(
      .CNT_W(CNT_W),
      .DEF_DIV(DEF_DIV),
      .DEF_HIGH(DEF_HIGH)
    ) u_ch (
      .I_CLK(I_CLK),
      .rst(rst),
      .en(en[g]),
      .acc(cfg.cfg_valid && cfg.cfg_ready && cfg.cfg_ch == CH_W'(g)),
      .div_in(cfg.cfg_div),
      .high_in(cfg.cfg_high),
      .pend(pend[g]),
      .dclk(O_CLK[g]),
      .tick(O_TICK[g])
    );
  end
endmodule

// File: tb/tb_multi_clk_divider.sv
// tb_multi_clk_divider: randomized scoreboard bench against a period-pattern reference model
module tb_multi_clk_divider;
  import mcd_pkg::*;
  localparam int CH = 3;
  localparam int CHW = ch_w(CH);
  logic I_CLK = 1'b0;
  logic rst = 1'b1;
  logic [CH-1:0] en;
  logic [CH-1:0] O_CLK, O_TICK;
  mcd_if #(.CH_W(CHW), .CNT_W(32)) cif();
  multi_clk_divider #(.CHANNELS(CH)) dut (
    .I_CLK(I_CLK),
    .rst(rst),
    .en(en),
    .cfg(cif.slave),
    .O_CLK(O_CLK),
    .O_TICK(O_TICK)
  );
  always #5 I_CLK = ~I_CLK;

  int total = 0;
  int passed = 0;
  int unsigned m_div[CH], m_high[CH], p_div[CH], p_high[CH];
  bit m_pend[CH];
  bit [1:0] pat[CH][$];
  logic [2*CH:0] exp_q[$];
  logic rdy_q[$];
  logic last_rdy;
  logic [CH-1:0] run;

  function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      m_div[i] = 100;
      m_high[i] = 50;
      m_pend[i] = 1'b0;
      pat[i].delete();
    end
    exp_q.delete();
    rdy_q.delete();
  endfunction

  function automatic void model_edge(logic [CH-1:0] e, logic v, logic [CHW-1:0] ch, int unsigned d, int unsigned h);
    logic [CH-1:0] oc, ot;
    logic bad, rdy;
    oc = '0;
    ot = '0;
    bad = int'(ch) >= CH;
    if (bad) rdy = 1'b1;
    else rdy = !m_pend[ch];
    for (int i = 0; i < CH; i++) begin
      if (e[i]) begin
        if (pat[i].size() == 0)
          for (int unsigned k = 0; k < m_div[i]; k++) pat[i].push_back({k < m_high[i], k == 0});
        {oc[i], ot[i]} = pat[i].pop_front();
      end else pat[i].delete();
      if (m_pend[i] && pat[i].size() == 0) begin
        m_div[i] = p_div[i];
        m_high[i] = p_high[i];
        m_pend[i] = 1'b0;
      end
    end
    if (v && rdy && !bad) begin
      m_pend[ch] = 1'b1;
      p_div[ch] = d < 2 ? 2 : d;
      p_high[ch] = h;
    end
    last_rdy = rdy;
    rdy_q.push_back(rdy);
    exp_q.push_back({oc, ot, v && bad});
  endfunction

  task automatic step(input logic [CH-1:0] e, input logic v, input logic [CHW-1:0] ch, input int unsigned d, input int unsigned h);
    @(negedge I_CLK);
    #1;
    en = e;
    cif.cfg_valid = v;
    cif.cfg_ch = ch;
    cif.cfg_div = d;
    cif.cfg_high = h;
    model_edge(e, v, ch, d, h);
  endtask

  task automatic idle(input int n);
    repeat (n) step(run, 1'b0, '0, 0, 0);
  endtask

  task automatic cfg_write(input logic [CHW-1:0] ch, input int unsigned d, input int unsigned h);
    int n = 0;
    do begin
      step(run, 1'b1, ch, d, h);
      n++;
    end while (!last_rdy && n < 400);
    if (!last_rdy) begin
      total++;
      $display("FAIL cfg_write_timeout: ch %0d never ready, required ready within 400 cycles", ch);
    end
  endtask

  task automatic do_reset();
    @(negedge I_CLK);
    #3;
    rst = 1'b1;
    #1;
    check("reset_outputs", 16'({O_CLK, O_TICK, cif.cfg_err}), 16'h0);
    model_reset();
    repeat (2) @(posedge I_CLK);
    #1;
    rst = 1'b0;
  endtask

  // monitor: compare the DUT against the scoreboard queues whenever it presents a value
  initial forever begin
    logic r;
    logic [2*CH:0] x;
    @(negedge I_CLK);
    #2;
    if (rdy_q.size() != 0) begin
      r = rdy_q.pop_front();
      check("cfg_ready", 16'(cif.cfg_ready), 16'(r));
    end
    @(posedge I_CLK);
    #1;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      check("clk_tick_err", 16'({O_CLK, O_TICK, cif.cfg_err}), 16'(x));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int idx;
    en = '1;
    cif.cfg_valid = 1'b0;
    cif.cfg_ch = '0;
    cif.cfg_div = '0;
    cif.cfg_high = '0;
    run = '1;
    model_reset();
    repeat (2) @(posedge I_CLK);
    #1;
    rst = 1'b0;
    idle(267);
    cfg_write(0, 7, 3);
    idle(60);
    cfg_write(0, 1, 1);
    idle(20);
    cfg_write(0, 5, 0);
    idle(20);
    cfg_write(0, 5, 9);
    idle(20);
    n = 0;
    while (pat[0].size() != 1 && n < 50) begin
      idle(1);
      n++;
    end
    if (pat[0].size() != 1) begin
      total++;
      $display("FAIL wrap_search: pattern depth %0d, required 1", pat[0].size());
    end
    cfg_write(0, 6, 2);
    cfg_write(0, 4, 1);
    idle(30);
    idle(2);
    run = 3'b110;
    idle(10);
    run = '1;
    idle(30);
    cfg_write(2'd3, 9, 9);
    idle(5);
    cfg_write(1, 3, 1);
    idle(2);
    do_reset();
    idle(210);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        idx = int'($urandom_range(0, CH - 1));
        run[idx] = !run[idx];
      end
      step(run, $urandom_range(0, 3) == 0, CHW'($urandom_range(0, 3)), $urandom_range(0, 12), $urandom_range(0, 14));
      if (c == 700) do_reset();
    end
    idle(3);
    @(posedge I_CLK);
    #3;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
